// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter for the single memory-mapped IO peripheral.
// Each access runs SETUP -> WAIT (reads only) -> RESP; all outputs are registered from next-state.
module io_bus_arbiter #(
  parameter int READ_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        pRead,
  output logic        pWrite,
  output logic [1:0]  addr,
  output logic [31:0] pWriteData,
  input  logic [31:0] pReadData,
  output logic        busy,
  output logic [1:0]  grant
);

  localparam logic [3:0] READ_WAIT_L = 4'(READ_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [1:0]  lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        capture_s;
  logic        win_s;

  logic        pread_q, pread_d;
  logic        pwrite_q, pwrite_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        busy_q, busy_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  ack_q, ack_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        drive_s;
  logic [1:0]  owner_oh_s;

  // Next-state: arbitration, request latching and the read wait counter.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    we_d        = we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    cnt_d       = cnt_q;
    capture_s   = 1'b0;
    win_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // On a tie the master that did not own the previous access wins.
        if (m0_req && m1_req) begin
          win_s = ~last_q;
        end else if (m1_req) begin
          win_s = 1'b1;
        end else begin
          win_s = 1'b0;
        end
        if (m0_req || m1_req) begin
          state_d     = ST_SETUP;
          owner_d     = win_s;
          last_d      = win_s;
          we_d        = win_s ? m1_we    : m0_we;
          lat_addr_d  = win_s ? m1_addr  : m0_addr;
          lat_wdata_d = win_s ? m1_wdata : m0_wdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (we_q) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = READ_WAIT_L;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          capture_s = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output next-values decoded from next-state so the registered outputs align with the state.
  always_comb begin
    drive_s    = (state_d == ST_SETUP) || (state_d == ST_WAIT);
    owner_oh_s = owner_d ? 2'b10 : 2'b01;
    pread_d    = ((state_d == ST_SETUP) && !we_d) || (state_d == ST_WAIT);
    pwrite_d   = (state_d == ST_SETUP) && we_d;
    addr_d     = drive_s ? lat_addr_d : 2'b00;
    pwdata_d   = drive_s ? lat_wdata_d : 32'h0000_0000;
    busy_d     = (state_d != ST_IDLE);
    grant_d    = busy_d ? owner_oh_s : 2'b00;
    ack_d      = (state_d == ST_RESP) ? owner_oh_s : 2'b00;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    if (capture_s) begin
      if (owner_q) begin
        rdata1_d = pReadData;
      end else begin
        rdata0_d = pReadData;
      end
    end else begin
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
    end
  end

  // Control state and latched request; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      lat_addr_q  <= 2'b00;
      lat_wdata_q <= 32'h0000_0000;
      cnt_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  // Registered bus, handshake and read-data outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pread_q  <= 1'b0;
      pwrite_q <= 1'b0;
      addr_q   <= 2'b00;
      pwdata_q <= 32'h0000_0000;
      busy_q   <= 1'b0;
      grant_q  <= 2'b00;
      ack_q    <= 2'b00;
      rdata0_q <= 32'h0000_0000;
      rdata1_q <= 32'h0000_0000;
    end else begin
      pread_q  <= pread_d;
      pwrite_q <= pwrite_d;
      addr_q   <= addr_d;
      pwdata_q <= pwdata_d;
      busy_q   <= busy_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign pRead      = pread_q;
  assign pWrite     = pwrite_q;
  assign addr       = addr_q;
  assign pWriteData = pwdata_q;
  assign busy       = busy_q;
  assign grant      = grant_q;
  assign m0_ack     = ack_q[0];
  assign m1_ack     = ack_q[1];
  assign m0_rdata   = rdata0_q;
  assign m1_rdata   = rdata1_q;

endmodule
